// File: rtl/uts_tx_if.sv
// Word handshake and serial-line bundle between a word source and uts_tx.
interface uts_tx_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              ale;
  logic              rmuadd;
  logic              busy;
  logic              done;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, ale, rmuadd, busy, done
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, ale, rmuadd, busy, done
  );
endinterface

// File: rtl/uts_tx.sv
// RMU serial-link transmitter: frames a word with ale, then shifts it out
// MSB-first on rmuadd, one bit per ps1 tick, followed by GAP_BITS idle bits.
module uts_tx #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned GAP_BITS = 1
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    ps1,
  uts_tx_if.slave bus
);
  localparam int unsigned CNT_W    = $clog2(DATA_W);
  localparam int unsigned GAP_W    = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam int unsigned GAP_LAST = (GAP_BITS > 0) ? GAP_BITS - 1 : 0;

  typedef enum logic [1:0] {IDLE, FRAME, SHIFT, GAP} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] shreg_q;
  logic [DATA_W-1:0] shreg_d;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [GAP_W-1:0]  gap_cnt_q;
  logic              ale_q;
  logic              rmuadd_q;
  logic              busy_q;
  logic              done_q;
  logic              accept;

  assign shreg_d      = {shreg_q[DATA_W-2:0], 1'b0};
  assign bus.tx_ready = (state_q == IDLE) && reset;
  assign accept       = bus.tx_valid && bus.tx_ready;

  assign bus.ale    = ale_q;
  assign bus.rmuadd = rmuadd_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

  // Frame sequencer; ps1 is only looked at from FRAME onwards.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      ale_q     <= 1'b0;
      rmuadd_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            shreg_q   <= bus.tx_data;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            ale_q     <= 1'b1;
            rmuadd_q  <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= FRAME;
          end
        end
        FRAME: begin
          if (ps1) begin
            ale_q    <= 1'b0;
            rmuadd_q <= shreg_q[DATA_W-1];
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          if (ps1) begin
            shreg_q <= shreg_d;
            if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
              rmuadd_q <= 1'b0;
              if (GAP_BITS == 0) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= IDLE;
              end else begin
                gap_cnt_q <= '0;
                state_q   <= GAP;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
              rmuadd_q  <= shreg_d[DATA_W-1];
            end
          end
        end
        GAP: begin
          if (ps1) begin
            if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              gap_cnt_q <= gap_cnt_q + GAP_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
